// File: rtl/reg_arbiter.sv
// reg_arbiter: round-robin arbiter sharing one single-port register file among NREQ requesters.
// Latency: gnt 1 cycle after req is sampled; rvalid/rdata exactly 2 cycles after the read's gnt.
// Backpressure: none; the pipeline never stalls and each granted requester sits out the next cycle.
//
// Ports:
//   clock, reset       clock and asynchronous active-high reset (shared with the register file)
//   req, req_we        per-requester request valid and write(1)/read(0) select
//   req_addr, req_din  packed per-requester address / write data (requester i at slot i)
//   gnt                registered one-hot grant pulse
//   rvalid, rdata      registered one-hot read-return pulse and its data
//   rf_we, rf_addr,    registered register-file controls
//   rf_din, rf_dout    register-file write data in, read data back
module reg_arbiter #(
   parameter int BIT  = 8,
   parameter int SZB  = 4,
   parameter int NREQ = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NREQ-1:0]     req,
   input  logic [NREQ-1:0]     req_we,
   input  logic [NREQ*SZB-1:0] req_addr,
   input  logic [NREQ*BIT-1:0] req_din,
   output logic [NREQ-1:0]     gnt,
   output logic [NREQ-1:0]     rvalid,
   output logic [BIT-1:0]      rdata,
   output logic                rf_we,
   output logic [SZB-1:0]      rf_addr,
   output logic [BIT-1:0]      rf_din,
   input  logic [BIT-1:0]      rf_dout
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   // state
   logic [PW-1:0]   ptr_q,     ptr_d;
   logic [NREQ-1:0] gnt_q,     gnt_d;
   logic            rf_we_q,   rf_we_d;
   logic [SZB-1:0]  rf_addr_q, rf_addr_d;
   logic [BIT-1:0]  rf_din_q,  rf_din_d;
   logic            s1_rd_q,   s1_rd_d;
   logic [PW-1:0]   s1_tag_q,  s1_tag_d;
   logic            s2_rd_q;
   logic [PW-1:0]   s2_tag_q;
   logic [NREQ-1:0] rvalid_q,  rvalid_d;
   logic [BIT-1:0]  rdata_q,   rdata_d;

   // arbitration
   logic [NREQ-1:0] elig;
   logic            found;
   logic [PW-1:0]   win;

   // Last cycle's winner is masked so it has a cycle to see gnt and drop or change req.
   assign elig = req & ~gnt_q;

   // First eligible requester at or after ptr, wrapping modulo NREQ.
   always_comb begin
      int idx;
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr_q) + k) % NREQ;
         if (!found && elig[idx]) begin
            found = 1'b1;
            win   = PW'(idx);
         end
      end
   end

   // Issue stage (S1) next state
   always_comb begin
      ptr_d     = ptr_q;
      gnt_d     = '0;
      rf_we_d   = 1'b0;
      rf_addr_d = rf_addr_q;
      rf_din_d  = rf_din_q;
      s1_rd_d   = 1'b0;
      s1_tag_d  = s1_tag_q;
      if (found) begin
         ptr_d     = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
         gnt_d     = NREQ'(1) << win;
         rf_we_d   = req_we[win];
         rf_addr_d = req_addr[SZB*int'(win) +: SZB];
         rf_din_d  = req_din[BIT*int'(win) +: BIT];
         s1_rd_d   = req[win] & ~req_we[win];
         s1_tag_d  = win;
      end
   end

   // Return stage (S3) next state: rf_dout holds the word addressed two edges ago.
   always_comb begin
      rvalid_d = '0;
      rdata_d  = rdata_q;
      if (s2_rd_q) begin
         rvalid_d = NREQ'(1) << s2_tag_q;
         rdata_d  = rf_dout;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr_q     <= '0;
         gnt_q     <= '0;
         rf_we_q   <= 1'b0;
         rf_addr_q <= '0;
         rf_din_q  <= '0;
         s1_rd_q   <= 1'b0;
         s1_tag_q  <= '0;
         s2_rd_q   <= 1'b0;
         s2_tag_q  <= '0;
         rvalid_q  <= '0;
         rdata_q   <= '0;
      end else begin
         ptr_q     <= ptr_d;
         gnt_q     <= gnt_d;
         rf_we_q   <= rf_we_d;
         rf_addr_q <= rf_addr_d;
         rf_din_q  <= rf_din_d;
         s1_rd_q   <= s1_rd_d;
         s1_tag_q  <= s1_tag_d;
         s2_rd_q   <= s1_rd_q;
         s2_tag_q  <= s1_tag_q;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
      end
   end

   assign gnt     = gnt_q;
   assign rvalid  = rvalid_q;
   assign rdata   = rdata_q;
   assign rf_we   = rf_we_q;
   assign rf_addr = rf_addr_q;
   assign rf_din  = rf_din_q;

endmodule

// File: tb/tb_reg_arbiter.sv
module tb_reg_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req = '0, req_we = '0;
   logic [15:0] req_addr = '0;
   logic [31:0] req_din = '0;
   logic [3:0]  gnt, rvalid;
   logic [7:0]  rdata;
   logic        rf_we;
   logic [3:0]  rf_addr;
   logic [7:0]  rf_din;
   logic [7:0]  rf_dout;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   reg_arbiter #(.BIT(8), .SZB(4), .NREQ(4)) dut (
      .clock(clock), .reset(reset),
      .req(req), .req_we(req_we), .req_addr(req_addr), .req_din(req_din),
      .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .rf_we(rf_we), .rf_addr(rf_addr), .rf_din(rf_din), .rf_dout(rf_dout)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Register file: write when we, otherwise registered read; cleared by the shared reset.
   logic [7:0] mem [16];
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) mem[i] <= '0;
         rf_dout <= '0;
      end else if (rf_we) begin
         mem[rf_addr] <= rf_din;
      end else begin
         rf_dout <= mem[rf_addr];
      end
   end

   typedef struct {
      logic [3:0]  req;
      logic [3:0]  we;
      logic [15:0] addr;
      logic [31:0] din;
      logic [3:0]  exp_gnt;
   } vec_t;

   typedef struct {
      int         due;
      logic [3:0] oh;
      logic [7:0] data;
   } exp_t;

   exp_t       sbq [$];
   logic [7:0] shadow [16];

   function automatic vec_t mk(input logic [3:0] r, input logic [3:0] w,
                               input logic [15:0] a, input logic [31:0] d,
                               input logic [3:0] g);
      vec_t v;
      v.req = r; v.we = w; v.addr = a; v.din = d; v.exp_gnt = g;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_outputs_zero(input string nm);
      chk({nm, " gnt"},     32'(gnt),     0);
      chk({nm, " rvalid"},  32'(rvalid),  0);
      chk({nm, " rdata"},   32'(rdata),   0);
      chk({nm, " rf_we"},   32'(rf_we),   0);
      chk({nm, " rf_addr"}, 32'(rf_addr), 0);
      chk({nm, " rf_din"},  32'(rf_din),  0);
   endtask

   task automatic clear_shadow();
      for (int i = 0; i < 16; i++) shadow[i] = '0;
   endtask

   // Drive one cycle of requests, check the grant, and record what the grant implies.
   task automatic apply_vec(input vec_t v, input string nm);
      int w;
      w = 0;
      req = v.req; req_we = v.we; req_addr = v.addr; req_din = v.din;
      @(posedge clock);
      @(negedge clock);
      chk({nm, " gnt"}, 32'(gnt), 32'(v.exp_gnt));
      if (v.exp_gnt != 0) begin
         for (int i = 0; i < 4; i++) if (v.exp_gnt[i]) w = i;
         if (v.we[w]) begin
            shadow[v.addr[4*w +: 4]] = v.din[8*w +: 8];
         end else begin
            sbq.push_back('{due: cyc + 2, oh: v.exp_gnt, data: shadow[v.addr[4*w +: 4]]});
         end
      end
   endtask

   // Read-return monitor
   always @(negedge clock) begin
      if (!reset) begin
         if (rvalid != 0) begin
            if (sbq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected rvalid: got %0h expected 0 at cycle %0d", rvalid, cyc);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("rvalid", 32'(rvalid), 32'(e.oh));
               chk("rdata", 32'(rdata), 32'(e.data));
               chk("rvalid latency", cyc, e.due);
            end
         end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
            exp_t e;
            e = sbq.pop_front();
            checks++; errors++;
            $display("FAIL missing rvalid: got 0 expected %0h at cycle %0d", e.oh, e.due);
         end
      end
   end

   vec_t tbl [24];

   initial begin
      // write/read, write sweep, full contention, back-to-back RAW, single held requester
      tbl[0]  = mk(4'b0001, 4'b0001, 16'h0003, 32'h000000A5, 4'b0001);
      tbl[1]  = mk(4'b0001, 4'b0000, 16'h0003, 32'h0,        4'b0000);
      tbl[2]  = mk(4'b0001, 4'b0000, 16'h0003, 32'h0,        4'b0001);
      tbl[3]  = mk(4'b1111, 4'b1111, 16'h7654, 32'h73625140, 4'b0010);
      tbl[4]  = mk(4'b1111, 4'b1111, 16'h7654, 32'h73625140, 4'b0100);
      tbl[5]  = mk(4'b1111, 4'b1111, 16'h7654, 32'h73625140, 4'b1000);
      tbl[6]  = mk(4'b1111, 4'b1111, 16'h7654, 32'h73625140, 4'b0001);
      tbl[7]  = mk(4'b1111, 4'b0000, 16'h7654, 32'h0,        4'b0010);
      tbl[8]  = mk(4'b1111, 4'b0000, 16'h7654, 32'h0,        4'b0100);
      tbl[9]  = mk(4'b1111, 4'b0000, 16'h7654, 32'h0,        4'b1000);
      tbl[10] = mk(4'b1111, 4'b0000, 16'h7654, 32'h0,        4'b0001);
      tbl[11] = mk(4'b1111, 4'b0000, 16'h7654, 32'h0,        4'b0010);
      tbl[12] = mk(4'b0001, 4'b0000, 16'h7654, 32'h0,        4'b0001);
      tbl[13] = mk(4'b0110, 4'b0010, 16'h0550, 32'h00003C00, 4'b0010);
      tbl[14] = mk(4'b0110, 4'b0010, 16'h0550, 32'h00003C00, 4'b0100);
      tbl[15] = mk(4'b0100, 4'b0000, 16'h0600, 32'h0,        4'b0000);
      tbl[16] = mk(4'b0100, 4'b0000, 16'h0600, 32'h0,        4'b0100);
      tbl[17] = mk(4'b0100, 4'b0000, 16'h0600, 32'h0,        4'b0000);
      tbl[18] = mk(4'b0100, 4'b0000, 16'h0600, 32'h0,        4'b0100);
      // req_we without req must not write address 3
      tbl[19] = mk(4'b0000, 4'b1111, 16'h3333, 32'hFFFFFFFF, 4'b0000);
      tbl[20] = mk(4'b0000, 4'b1111, 16'h3333, 32'hFFFFFFFF, 4'b0000);
      tbl[21] = mk(4'b0001, 4'b0000, 16'h0003, 32'h0,        4'b0001);
      tbl[22] = mk(4'b0000, 4'b0000, 16'h0000, 32'h0,        4'b0000);
      tbl[23] = mk(4'b0000, 4'b0000, 16'h0000, 32'h0,        4'b0000);

      clear_shadow();
      #1;
      chk_outputs_zero("power-on reset");
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < 24; i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

      // Reset with a read in flight: the read of address 5 must never return.
      apply_vec(mk(4'b0010, 4'b0000, 16'h0050, 32'h0, 4'b0010), "inflight read");
      req = '0; req_we = '0;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      sbq.delete();
      clear_shadow();
      #1;
      chk_outputs_zero("mid-run reset");
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 4; i++)
         apply_vec(mk(4'b0000, 4'b0000, 16'h0, 32'h0, 4'b0000), $sformatf("post-reset idle%0d", i));

      // Pointer restarts at 0 and the register file reads back cleared.
      apply_vec(mk(4'b1111, 4'b0000, 16'h3353, 32'h0, 4'b0001), "post-reset rd0");
      apply_vec(mk(4'b1111, 4'b0000, 16'h3353, 32'h0, 4'b0010), "post-reset rd1");
      for (int i = 0; i < 3; i++)
         apply_vec(mk(4'b0000, 4'b0000, 16'h0, 32'h0, 4'b0000), $sformatf("drain%0d", i));

      chk("scoreboard empty", 32'(sbq.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_arbiter.md
# reg_arbiter

Round-robin arbiter that shares the single-port register file (`reg_inst`) among `NREQ` requesters. It accepts read or write requests, grants one per cycle, and drives the register file's `we`/`addr`/`din` from registers. It returns read data tagged to the originating requester. It sits between the pipeline stages that access architectural registers and the register file instance.

## Interface
- `BIT`, default 8: data width, matching the register file `BIT`.
- `SZB`, default 4: address width, giving 2^SZB registers and matching the register file `SZB`.
- `NREQ`, default 4: number of requesters, at least 2.

Ports:
- `clock`, input, 1 bit: clock.
- `reset`, input, 1 bit: reset, asynchronous, active-high. The same reset drives `reg_inst`.
- `req`, input, `NREQ` bits: request valid, one bit per requester.
- `req_we`, input, `NREQ` bits: 1 means write, 0 means read, one bit per requester.
- `req_addr`, input, `NREQ*SZB` bits: packed addresses; requester i occupies `[SZB*(i+1)-1 : SZB*i]`.
- `req_din`, input, `NREQ*BIT` bits: packed write data, same packing as `req_addr`.
- `gnt`, output, `NREQ` bits: registered one-hot grant pulse.
- `rvalid`, output, `NREQ` bits: registered one-hot read-data-valid pulse.
- `rdata`, output, `BIT` bits: read data, qualified by `rvalid`.
- `rf_we`, output, 1 bit: drives the register file `we`.
- `rf_addr`, output, `SZB` bits: drives the register file `addr`.
- `rf_din`, output, `BIT` bits: drives the register file `din`.
- `rf_dout`, input, `BIT` bits: from the register file `dout`.

## Operation
- **Round-robin pointer.** `ptr` holds `clog2(NREQ)` bits and resets to 0. The winner is the first i with `elig[i]`, searching from `ptr` upward and wrapping modulo `NREQ`. After a grant, `ptr` becomes winner+1, wrapping `NREQ-1` to 0. `ptr` is unchanged when nothing is granted.
- **Eligibility.** `elig = req & ~gnt`. A requester granted in the previous cycle is masked for one cycle, which gives it one cycle to drop or replace `req` after it sees the registered `gnt`. A continuously requesting single requester therefore gets a grant every second cycle.
- **Issue stage (S1).** On a grant at edge t, the block registers:
  - `gnt` to the winner's one-hot;
  - `rf_we` to `req_we[w]`;
  - `rf_addr` to `req_addr[w]`;
  - `rf_din` to `req_din[w]`;
  - `s1_rd` to `req[w] & ~req_we[w]`;
  - `s1_tag` to w.
- **No grant at edge t.** `gnt` becomes 0, `rf_we` becomes 0, `s1_rd` becomes 0, and `rf_addr`/`rf_din` hold.
- **Register-file stage (S2).** At edge t+1 the register file writes if `rf_we`=1, otherwise it loads `dout` from `rf_addr`. The block registers `s2_rd` from `s1_rd` and `s2_tag` from `s1_tag`.
- **Return stage (S3).** At edge t+2, if `s2_rd`, then `rdata` takes `rf_dout` and `rvalid` takes the one-hot of `s2_tag`. Otherwise `rvalid` becomes 0 and `rdata` holds.
- **Writes.** Writes produce no `rvalid`. A write is complete once its grant has been issued.
- **Throughput and reordering.** One operation is issued per cycle. The pipeline never stalls, so there is no backpressure on `rvalid`, and data is never reordered.
- **Read-after-write.** A write granted at edge t followed by a read of the same address granted at edge t+1 returns the new data, because the register file writes at t+1 and reads at t+2. The block needs no hazard logic.
- **Reset values.** Reset clears `gnt`, `rvalid`, `rdata`, `rf_we`, `rf_addr`, `rf_din`, `ptr`, `s1_rd`, `s2_rd` and the tags to 0. A read in flight when reset is asserted is dropped with no `rvalid`.
- **`req_we` with `req`=0.** `req_we` is ignored when the corresponding `req` is 0.

## Timing
- Grant latency: `gnt[i]` goes high 1 cycle after `req[i]` is sampled, if i wins.
- Read latency: `rvalid[i]` goes high exactly 2 cycles after `gnt[i]`, with `rdata` valid in that same cycle.
- `gnt` and `rvalid` are single-cycle pulses, each with at most one bit set.
- There are no combinational paths from inputs to outputs.

## Test plan
- **Reset.** Assert reset mid-run. All outputs must read 0 immediately, and no `rvalid` may appear afterwards.
- **Write then read.** req0 writes 0xA5 to address 3. After its grant, req0 reads address 3. `rvalid[0]` must pulse 2 cycles after the read `gnt[0]`, with `rdata`=0xA5.
- **Full contention.** All four requesters hold read requests continuously. `gnt` must sequence 1,2,3,0,1,… from `ptr`=0 after the first grant to 0, one grant per cycle, with each `rvalid` arriving 2 cycles after its grant.
- **Back-to-back read-after-write.** req1 writes 0x3C to address 5, granted in cycle n. req2 reads address 5, granted in cycle n+1. `rvalid[2]` must appear in cycle n+3 with `rdata`=0x3C.
- **Single requester held.** Only req2 holds `req`. `gnt[2]` must pulse every other cycle.
- **Reset with a read in flight.** Assert reset 1 cycle after a read `gnt`. There must be no `rvalid`, and a read of any address after reset must return 0.
